x1_vram_arbiter: RTL

//  Shares one single-port synchronous VRAM (text/attr/graphic plane) between the CRTC display

---
 rtl/x1_pkg.sv | 8 +
 rtl/x1_vram_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/x1_pkg.sv
// Shared X1 VRAM sizing (used by the CRTC and bus decoder too) and the
// state encoding of the VRAM arbiter.
package x1_pkg;
  localparam int X1_VRAM_ADDR_W = 14;
  localparam int X1_VRAM_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, VID_A, VID_D, CPU_A, CPU_D, CPU_W} arb_state_t;
endpackage

// File: rtl/x1_vram_arbiter.sv
// Shares the single-port VRAM between CRTC display fetch and the Z80 bus.
// Video has priority; a streak limit bounds how long the CPU can be held.
module x1_vram_arbiter
  import x1_pkg::*;
#(
  parameter int ADDR_W        = X1_VRAM_ADDR_W,
  parameter int DATA_W        = X1_VRAM_DATA_W,
  parameter int VID_BURST_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int STREAK_W = $clog2(VID_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VID_BURST_MAX);

  arb_state_t          state_q;
  logic                vid_pend_q;
  logic [ADDR_W-1:0]   vid_addr_q;
  logic                cpu_mask_q;
  logic [STREAK_W-1:0] streak_q;

  logic              arb_en, vreq, creq, vid_gnt, cpu_gnt;
  logic [ADDR_W-1:0] vid_gnt_addr;

  // A finishing video read hands the RAM straight to the next grant; a CPU
  // read returns to IDLE first so its ack cycle can be masked.
  always_comb begin
    arb_en       = (state_q == IDLE) || (state_q == VID_D);
    vreq         = vid_req | vid_pend_q;
    creq         = cpu_req & ~cpu_mask_q;
    vid_gnt      = arb_en & vreq & (~creq | (streak_q < STREAK_MAX));
    cpu_gnt      = arb_en & creq & ~vid_gnt;
    vid_gnt_addr = vid_req ? vid_addr : vid_addr_q;
  end

  assign cpu_wait = cpu_req & ~cpu_ack;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      cpu_mask_q  <= 1'b0;
      streak_q    <= '0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      vid_overrun <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
    end else begin
      vid_valid  <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_mask_q <= 1'b0;

      case (state_q)
        VID_A: state_q <= VID_D;
        VID_D: begin
          vid_data  <= ram_rdata;
          vid_valid <= 1'b1;
          state_q   <= IDLE;
        end
        CPU_A: state_q <= CPU_D;
        CPU_D: begin
          cpu_rdata  <= ram_rdata;
          cpu_ack    <= 1'b1;
          cpu_mask_q <= 1'b1;
          state_q    <= IDLE;
        end
        CPU_W: begin
          ram_we     <= 1'b0;
          cpu_ack    <= 1'b1;
          cpu_mask_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (vid_gnt) begin
        state_q  <= VID_A;
        ram_addr <= vid_gnt_addr;
        ram_we   <= 1'b0;
        if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
      end else if (cpu_gnt) begin
        ram_addr <= cpu_addr;
        streak_q <= '0;
        if (cpu_we) begin
          ram_we    <= 1'b1;
          ram_wdata <= cpu_wdata;
          state_q   <= CPU_W;
        end else begin
          ram_we  <= 1'b0;
          state_q <= CPU_A;
        end
      end

      if (!cpu_req) streak_q <= '0;

      // A second strobe before the first is served is a display underrun;
      // the newest address wins.
      if (vid_req && vid_pend_q) vid_overrun <= 1'b1;
      if (vid_gnt) begin
        vid_pend_q <= 1'b0;
      end else if (vid_req) begin
        vid_pend_q <= 1'b1;
        vid_addr_q <= vid_addr;
      end
    end
  end
endmodule
